updown_step_ctrl: RTL and testbench

Input-conditioning stage that sits directly upstream of the two-bit up/down counter. It synchronises and debounces a raw push-button and a raw mode switch, and emits two signals for the counter:
- a single-cycle `step` enable;
- a clean, registered mode `m` (0 = up, 1 = down).

Holding the button auto-repeats after a delay, so the counter can be driven from board buttons without glitches or multiple counts per press.

---
 rtl/updown_ctrl_pkg.sv | 9 +
 rtl/updown_step_ctrl_sync_debounce.sv | 40 ++++
 rtl/updown_step_ctrl.sv | 81 ++++++++
 tb/tb_updown_step_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/updown_ctrl_pkg.sv
// Shared types and encodings for the up/down counter input-conditioning stage.
package updown_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} step_state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/updown_step_ctrl_sync_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer for one raw input.
// `toggle` flags that `level` takes the synchronised value on the coming edge.
module sync_debounce #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic toggle
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] count;

  assign toggle = (sync[1] != level) && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= 2'b00;
      level <= RESET_LEVEL;
      count <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (toggle) begin
        level <= sync[1];
        count <= '0;
      end else if (sync[1] != level) begin
        count <= count + CW'(1);
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/updown_step_ctrl.sv
// Button/mode conditioning for the up/down counter: debounced mode, single-cycle
// step on press, auto-repeat while held, and direction-change restart of the delay.
module updown_step_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic m_raw,
  output logic step,
  output logic m,
  output logic held
);

  localparam int IMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int IW   = $clog2(IMAX + 1);
  localparam logic [IW-1:0] DELAY_LOAD  = IW'(REPEAT_DELAY - 1);
  localparam logic [IW-1:0] PERIOD_LOAD = IW'(REPEAT_PERIOD - 1);

  step_state_t   state;
  logic [IW-1:0] interval;
  logic          m_toggle;
  logic          unused_btn_toggle;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_btn (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_raw),
    .level  (held),
    .toggle (unused_btn_toggle)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(MODE_UP)) u_mode (
    .clk    (clk),
    .reset  (reset),
    .raw    (m_raw),
    .level  (m),
    .toggle (m_toggle)
  );

  // Interval counter counts down to zero; a mode toggle is acted on in the same
  // edge the debounced mode flips, so no pulse ever carries the stale direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      interval <= '0;
      step     <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          if (held) begin
            state    <= DELAY;
            interval <= DELAY_LOAD;
            step     <= 1'b1;
          end
        end
        DELAY, REPEAT: begin
          if (!held) begin
            state <= IDLE;
          end else if (m_toggle) begin
            state    <= DELAY;
            interval <= DELAY_LOAD;
          end else if (interval == '0) begin
            state    <= REPEAT;
            interval <= PERIOD_LOAD;
            step     <= 1'b1;
          end else begin
            interval <= interval - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updown_step_ctrl.sv
// Directed bench for updown_step_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_updown_step_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_raw = 1'b0;
  logic m_raw = 1'b0;
  logic step, m, held;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic btn;
    logic mr;
    logic st;
    logic m;
    logic held;
  } vec_t;

  vec_t vecs[$];

  updown_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .m_raw   (m_raw),
    .step    (step),
    .m       (m),
    .held    (held)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input int n, input logic b, input logic mr, input logic st,
                     input logic mm, input logic h);
    vec_t v;
    v.btn = b; v.mr = mr; v.st = st; v.m = mm; v.held = h;
    repeat (n) vecs.push_back(v);
  endtask

  function automatic bit inlist(input int k, input int q[$]);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // Button pressed before edge 0 and released before edge btn_until; m_raw high
  // from m_from (negative = never) until the end of the run.
  task automatic run_seq(input string name, input int cycles, input int btn_until,
                         input int m_from, input int pulses[$]);
    for (int k = 0; k < cycles; k++) begin
      btn_raw = (k < btn_until);
      m_raw   = (m_from >= 0) && (k >= m_from);
      tick();
      check({name, "_step"}, k, step, inlist(k, pulses));
      if (k == btn_until + 4) check({name, "_held_hi"}, k, held, 1'b1);
      if (k == btn_until + 5) check({name, "_held_lo"}, k, held, 1'b0);
      if (m_from >= 0 && k == m_from + 4) check({name, "_m_old"}, k, m, 1'b0);
      if (m_from >= 0 && k == m_from + 5) check({name, "_m_new"}, k, m, 1'b1);
    end
    btn_raw = 1'b0;
    m_raw   = 1'b0;
    repeat (12) tick();
    check({name, "_idle_m"}, 0, m, 1'b0);
    check({name, "_idle_held"}, 0, held, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low while both inputs toggle.
    for (int k = 0; k < 8; k++) begin
      btn_raw = k[0];
      m_raw   = k[1];
      tick();
      check("rst_step", k, step, 1'b0);
      check("rst_m", k, m, 1'b0);
      check("rst_held", k, held, 1'b0);
    end
    btn_raw = 1'b0;
    m_raw   = 1'b0;
    reset   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post_rst_step", k, step, 1'b0);
    end

    // Clean press: 5 cycles high then release.
    add(5, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 1);
    add(3, 0, 0, 0, 0, 1);
    add(6, 0, 0, 0, 0, 0);
    // Bounce with runs of 1..3, then a stable press released just before the
    // first repeat would be due.
    add(2, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(5, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1);
    add(1, 1, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 1);
    add(5, 0, 0, 0, 0, 1);
    add(5, 0, 0, 0, 0, 0);
    // Mode switch while idle: no step, m follows after 5 edges each way.
    add(5, 0, 1, 0, 0, 0);
    add(3, 0, 1, 0, 1, 0);
    add(5, 0, 0, 0, 1, 0);
    add(3, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      btn_raw = vecs[i].btn;
      m_raw   = vecs[i].mr;
      tick();
      check("tbl_step", i, step, vecs[i].st);
      check("tbl_m", i, m, vecs[i].m);
      check("tbl_held", i, held, vecs[i].held);
    end

    // Auto-repeat for a 30-cycle hold, pulses stop after release.
    run_seq("repeat", 46, 30, -1, '{6, 14, 17, 20, 23, 26, 29, 32, 35});
    // Mode flip during REPEAT lands on a due pulse: suppressed, restart delay.
    run_seq("mode_hold", 45, 34, 18, '{6, 14, 17, 20, 31, 34, 37});
    // Mode accepted in the same edge as the press: step fires, no restart.
    run_seq("mode_press", 25, 16, 1, '{6, 14, 17, 20});

    // Reset asserted mid-hold right after a repeat pulse.
    m_raw = 1'b1;
    for (int k = 0; k < 18; k++) begin
      btn_raw = 1'b1;
      tick();
    end
    check("midhold_pulse", 17, step, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_step", 0, step, 1'b0);
    check("abort_m", 0, m, 1'b0);
    check("abort_held", 0, held, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("abort_hold_step", k, step, 1'b0);
    end
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("fresh_step", k, step, k == 6);
      if (k == 4) check("fresh_held_lo", k, held, 1'b0);
      if (k == 5) check("fresh_held_hi", k, held, 1'b1);
    end
    btn_raw = 1'b0;
    m_raw   = 1'b0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
